audioplay_sw_debounce: RTL and testbench
========================================

AUDIOPLAY_SW_DEBOUNCE -- requirements
Module: audioplay_sw_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the confirm count N (legal range 2 to 2^CNT_W-1); the default is 1 ms at 50 MHz.
REQ-002 Parameter CNT_W, default 16, SHALL set the debounce counter width.
REQ-003 Parameter INVERT, default 0, SHALL invert pin_in before synchronisation when set to 1 (active-low switches).
REQ-004 The module SHALL have one clock, clk, and a synchronous, active-low reset, reset_n.
REQ-005 clk  input  1  system clock; every register SHALL update on its rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 pin_in  input  1  raw asynchronous switch or button pin.
REQ-008 edge_clr  input  1  clears edge_cap when high for one cycle.
REQ-009 level_out  output  1  debounced level; drives the filter-select PIO in_port.
REQ-010 rise_pulse  output  1  one-cycle strobe on a debounced 0->1 transition.
REQ-011 fall_pulse  output  1  one-cycle strobe on a debounced 1->0 transition.
REQ-012 edge_cap  output  1  sticky edge flag.

Function
REQ-013 The module SHALL pass pin_in (after the INVERT XOR) through a two-flop synchronizer, s1 -> s2; only s2 SHALL feed the FSM.
REQ-014 The FSM SHALL have four states: IDLE_LO, CONFIRM_HI, IDLE_HI and CONFIRM_LO.
REQ-015 In IDLE_LO with s2=1, the FSM SHALL go to CONFIRM_HI and load cnt=0; IDLE_HI with s2=0 SHALL go to CONFIRM_LO and load cnt=0.
REQ-016 In CONFIRM_HI:
- s2=1 and cnt<N-1: cnt SHALL increment.
- s2=1 and cnt=N-1: the FSM SHALL go to IDLE_HI, set level_out=1 and assert rise_pulse for exactly one cycle.
- s2=0: the FSM SHALL return to IDLE_LO and clear cnt; level_out SHALL not change.
REQ-017 CONFIRM_LO SHALL mirror CONFIRM_HI with polarity swapped: go to IDLE_LO, set level_out=0 and pulse fall_pulse.
REQ-018 Latency: with pin stable after the first sampling edge E0, level_out SHALL change at edge E0+N+2.
REQ-019 Glitch rejection: any s2 excursion shorter than N+1 consecutive cycles SHALL leave level_out and both pulse outputs unchanged.
REQ-020 rise_pulse and fall_pulse SHALL never be high in the same cycle, and each pulse SHALL coincide with the cycle in which level_out first shows its new value.
REQ-021 cnt SHALL never exceed N-1 and SHALL never wrap.
REQ-022 All outputs SHALL be registered, with no combinational path from pin_in to any output.

Reset
REQ-023 While reset_n=0 at a clk edge, the following SHALL be cleared:
- s1 and s2 to 0;
- state to IDLE_LO and cnt to 0;
- level_out, rise_pulse, fall_pulse and edge_cap to 0.
REQ-024 A reset asserted during CONFIRM_* SHALL abort the confirmation and emit no pulse.
REQ-025 With INVERT=1 and the pin idle high, level_out SHALL stay 0 after reset with no spurious pulse.

Configuration
REQ-026 With macro AUDIOPLAY_SW_EDGE_CAPTURE_EN defined, edge_cap SHALL set on rise_pulse or fall_pulse and clear on edge_clr.
REQ-027 When a set and edge_clr coincide in the same cycle, set SHALL win.
REQ-028 Without AUDIOPLAY_SW_EDGE_CAPTURE_EN, edge_cap SHALL be tied to 0 and edge_clr SHALL be ignored; the port list SHALL be identical in both builds.

Structure
REQ-029 Package audioplay_sw_pkg SHALL hold the FSM state typedef (2-bit enum), the DEBOUNCE_CYCLES default and the CNT_W default.
REQ-030 The synchronizer SHALL be a sub-module named audioplay_sync2 (1-bit, two flops, synchronous active-low reset).

Verification
REQ-031 The bench SHALL run with N=4 and cover these scenarios:
- Clean press: pin 0->1 held 20 cycles -> level_out=1 at E0+6, rise_pulse high exactly one cycle.
- Bounce: pin toggles high 3 cycles, low 2 cycles, three times, then held high -> one rise_pulse only, timed from the final stable rise.
- Glitch: 4-cycle high pulse on pin -> level_out stays 0, no pulses.
- Release: pin 1->0 from IDLE_HI -> fall_pulse once, level_out=0 at E0+6.
- Reset mid-CONFIRM_HI (cnt=2) -> all outputs 0 and no pulse; after release, stable high -> full N+2 latency again.
- Edge capture (macro defined): rise sets edge_cap; edge_clr in the same cycle as fall_pulse -> edge_cap stays 1; edge_clr alone -> 0. Without the macro, edge_cap stays 0.

Source files
------------

// File: rtl/audioplay_sw_pkg.sv
// audioplay_sw_pkg: shared types and defaults for the switch debouncer.
//   state_e              - 2-bit debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEF  - default confirm count (1 ms at 50 MHz)
//   CNT_W_DEF            - default debounce counter width
package audioplay_sw_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned CNT_W_DEF           = 16;

  typedef enum logic [1:0] {
    IDLE_LO    = 2'd0,
    CONFIRM_HI = 2'd1,
    IDLE_HI    = 2'd2,
    CONFIRM_LO = 2'd3
  } state_e;

endpackage : audioplay_sw_pkg

// File: rtl/audioplay_sync2.sv
// audioplay_sync2: 1-bit two-flop synchronizer for an asynchronous input.
//   clk     - destination clock
//   reset_n - synchronous active-low reset, clears both flops
//   d       - asynchronous input
//   q       - synchronized output (second flop)
module audioplay_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Plain shift: s1 may go metastable, s2 gives it a cycle to settle.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule : audioplay_sync2

// File: rtl/audioplay_sw_debounce.sv
// audioplay_sw_debounce: debounces one raw switch/button pin.
// A level change is accepted only after the synchronized pin has held the
// new value for DEBOUNCE_CYCLES+1 consecutive samples; level_out then
// changes and a one-cycle rise/fall strobe is emitted with it.
//
// Parameters:
//   DEBOUNCE_CYCLES - confirm count N (2 .. 2^CNT_W-1)
//   CNT_W           - confirm counter width
//   INVERT          - 1 inverts pin_in ahead of the synchronizer
// Ports:
//   clk        - system clock
//   reset_n    - synchronous active-low reset
//   pin_in     - raw asynchronous pin
//   edge_clr   - clears edge_cap
//   level_out  - debounced level (registered)
//   rise_pulse - one-cycle strobe on debounced 0->1 (registered)
//   fall_pulse - one-cycle strobe on debounced 1->0 (registered)
//   edge_cap   - sticky edge flag (registered)
// Build option:
//   AUDIOPLAY_SW_EDGE_CAPTURE_EN - enables the sticky edge_cap flag;
//   otherwise edge_cap is held at 0 and edge_clr is ignored.
module audioplay_sw_debounce
  import audioplay_sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned INVERT          = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_in,
  input  logic edge_clr,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic edge_cap
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             PIN_POL  = (INVERT != 0);

  logic pin_pol;
  logic s2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             edge_cap_q, edge_cap_d;

  // Polarity fix-up happens before synchronization so the FSM is polarity-agnostic.
  assign pin_pol = pin_in ^ PIN_POL;

  audioplay_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pin_pol),
    .q       (s2)
  );

  // Debounce FSM: next state, counter and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      IDLE_LO: begin
        if (s2) begin
          state_d = CONFIRM_HI;
          cnt_d   = '0;
        end
      end

      CONFIRM_HI: begin
        if (!s2) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      IDLE_HI: begin
        if (!s2) begin
          state_d = CONFIRM_LO;
          cnt_d   = '0;
        end
      end

      CONFIRM_LO: begin
        if (s2) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUDIOPLAY_SW_EDGE_CAPTURE_EN
  // Sticky flag set from the registered strobes; a set beats a same-cycle clear.
  always_comb begin
    edge_cap_d = edge_cap_q;
    if (edge_clr) begin
      edge_cap_d = 1'b0;
    end
    if (rise_q || fall_q) begin
      edge_cap_d = 1'b1;
    end
  end
`else
  logic unused_edge_clr;
  assign unused_edge_clr = edge_clr;

  always_comb begin
    edge_cap_d = 1'b0;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE_LO;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign edge_cap   = edge_cap_q;

endmodule : audioplay_sw_debounce

// File: tb/tb_audioplay_sw_debounce.sv
// tb_audioplay_sw_debounce: self-checking bench for audioplay_sw_debounce
// with N=4. Two instances run side by side: one with INVERT=0 and one with
// INVERT=1 fed the complemented pin; both must match one behavioural model.
module tb_audioplay_sw_debounce;

  localparam int unsigned N = 4;

  logic clk;
  logic reset_n;
  logic pin;
  logic pin_n;
  logic edge_clr;

  logic level_out, rise_pulse, fall_pulse, edge_cap;
  logic level_inv, rise_inv, fall_inv, cap_inv;

  assign pin_n = ~pin;

  audioplay_sw_debounce #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (8),
    .INVERT          (0)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pin_in     (pin),
    .edge_clr   (edge_clr),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_cap   (edge_cap)
  );

  audioplay_sw_debounce #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (8),
    .INVERT          (1)
  ) u_dut_inv (
    .clk        (clk),
    .reset_n    (reset_n),
    .pin_in     (pin_n),
    .edge_clr   (edge_clr),
    .level_out  (level_inv),
    .rise_pulse (rise_inv),
    .fall_pulse (fall_inv),
    .edge_cap   (cap_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pin history (2-sample sync delay) plus a run length of
  // consecutive samples that disagree with the accepted level.
  logic [1:0] m_hist;
  logic       m_level, m_rise, m_fall, m_cap;
  int         m_run;

  int cyc, nrise, nfall, rise_cyc, fall_cyc;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic p, input logic clr, input logic rn);
    logic seen;
    if (!rn) begin
      m_hist  = 2'b00;
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_cap   = 1'b0;
      m_run   = 0;
    end else begin
      seen = m_hist[1];
`ifdef AUDIOPLAY_SW_EDGE_CAPTURE_EN
      m_cap = m_rise | m_fall | (m_cap & ~clr);
`else
      m_cap = 1'b0;
`endif
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (seen != m_level) begin
        m_run++;
        if (m_run == int'(N) + 1) begin
          m_level = seen;
          m_rise  = seen;
          m_fall  = ~seen;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_hist = {m_hist[0], p};
    end
  endtask

  // One clock: apply inputs, advance model at the edge, check 1 time unit later.
  task automatic step(input logic p, input logic clr, input logic rn);
    pin      = p;
    edge_clr = clr;
    reset_n  = rn;
    @(posedge clk);
    model_edge(p, clr, rn);
    #1;
    cyc++;
    chk("level", int'(level_out), int'(m_level));
    chk("rise", int'(rise_pulse), int'(m_rise));
    chk("fall", int'(fall_pulse), int'(m_fall));
    chk("edge_cap", int'(edge_cap), int'(m_cap));
    chk("inv_level", int'(level_inv), int'(m_level));
    chk("inv_rise", int'(rise_inv), int'(m_rise));
    chk("inv_fall", int'(fall_inv), int'(m_fall));
    chk("inv_edge_cap", int'(cap_inv), int'(m_cap));
    chk("pulse_excl", int'(rise_pulse & fall_pulse), 0);
    if (rise_pulse) begin
      nrise++;
      rise_cyc = cyc;
    end
    if (fall_pulse) begin
      nfall++;
      fall_cyc = cyc;
    end
  endtask

  task automatic hold(input logic p, input int n);
    for (int i = 0; i < n; i++) step(p, 1'b0, 1'b1);
  endtask

  task automatic clear_counts();
    nrise    = 0;
    nfall    = 0;
    rise_cyc = -1;
    fall_cyc = -1;
  endtask

  int  c0;
  bit  found;
  logic rp;
  int   seg;

  initial begin
    pin      = 1'b0;
    edge_clr = 1'b0;
    reset_n  = 1'b0;
    cyc      = 0;
    m_hist   = 2'b00;
    m_level  = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_cap    = 1'b0;
    m_run    = 0;
    clear_counts();

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_level", int'(level_out), 0);
    chk("reset_cap", int'(edge_cap), 0);
    hold(1'b0, 5);

    // Clean press: level at E0+6, exactly one rise
    clear_counts();
    step(1'b1, 1'b0, 1'b1);
    c0 = cyc;
    hold(1'b1, 19);
    chk("press_latency", rise_cyc - c0, int'(N) + 2);
    chk("press_nrise", nrise, 1);
    chk("press_level", int'(level_out), 1);

    // Release: one fall at E0+6
    clear_counts();
    step(1'b0, 1'b0, 1'b1);
    c0 = cyc;
    hold(1'b0, 19);
    chk("release_latency", fall_cyc - c0, int'(N) + 2);
    chk("release_nfall", nfall, 1);
    chk("release_level", int'(level_out), 0);

    // Glitch: 4-cycle high pulse is rejected
    clear_counts();
    hold(1'b1, 4);
    hold(1'b0, 12);
    chk("glitch_nrise", nrise, 0);
    chk("glitch_nfall", nfall, 0);
    chk("glitch_level", int'(level_out), 0);

    // Bounce: 3 high / 2 low x3, then held high
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 3);
      hold(1'b0, 2);
    end
    step(1'b1, 1'b0, 1'b1);
    c0 = cyc;
    hold(1'b1, 19);
    chk("bounce_nrise", nrise, 1);
    chk("bounce_latency", rise_cyc - c0, int'(N) + 2);
    hold(1'b0, 20);

    // Reset during CONFIRM_HI with cnt=2
    clear_counts();
    step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 4);
    step(1'b1, 1'b0, 1'b0);
    chk("rstmid_level", int'(level_out), 0);
    chk("rstmid_rise", int'(rise_pulse), 0);
    chk("rstmid_cap", int'(edge_cap), 0);
    step(1'b1, 1'b0, 1'b1);
    c0 = cyc;
    hold(1'b1, 14);
    chk("rstmid_nrise", nrise, 1);
    chk("rstmid_latency", rise_cyc - c0, int'(N) + 2);

    // Edge capture: set on strobe, set beats clear, clear alone clears
    step(1'b1, 1'b0, 1'b0);
    hold(1'b0, 4);
    hold(1'b1, 10);
`ifdef AUDIOPLAY_SW_EDGE_CAPTURE_EN
    chk("cap_after_rise", int'(edge_cap), 1);
`else
    chk("cap_after_rise", int'(edge_cap), 0);
`endif
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (fall_pulse) found = 1'b1;
    end
    chk("cap_fall_seen", int'(found), 1);
    step(1'b0, 1'b1, 1'b1);
`ifdef AUDIOPLAY_SW_EDGE_CAPTURE_EN
    chk("cap_set_wins", int'(edge_cap), 1);
`else
    chk("cap_set_wins", int'(edge_cap), 0);
`endif
    step(1'b0, 1'b1, 1'b1);
    chk("cap_cleared", int'(edge_cap), 0);
    hold(1'b0, 3);

    // Randomized segments with sporadic clears and resets
    for (int s = 0; s < 400; s++) begin
      rp  = 1'($urandom_range(0, 1));
      seg = int'($urandom_range(1, 9));
      for (int i = 0; i < seg; i++) begin
        step(rp, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 299) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_audioplay_sw_debounce
